// File: rtl/alu_pkg.sv
// Shared constants, opcodes and FSM encoding for the shared-ALU arbiter.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 16;
   localparam int unsigned ALU_OPW   = 4;
   localparam int unsigned ALU_SHW   = 4;

   localparam logic [ALU_OPW-1:0] OP_ADD = ALU_OPW'(0);
   localparam logic [ALU_OPW-1:0] OP_SUB = ALU_OPW'(1);
   localparam logic [ALU_OPW-1:0] OP_AND = ALU_OPW'(2);
   localparam logic [ALU_OPW-1:0] OP_OR  = ALU_OPW'(3);
   localparam logic [ALU_OPW-1:0] OP_XOR = ALU_OPW'(4);
   localparam logic [ALU_OPW-1:0] OP_NOT = ALU_OPW'(5);
   localparam logic [ALU_OPW-1:0] OP_SLL = ALU_OPW'(6);
   localparam logic [ALU_OPW-1:0] OP_SRL = ALU_OPW'(7);
   localparam logic [ALU_OPW-1:0] OP_SRA = ALU_OPW'(8);
   localparam logic [ALU_OPW-1:0] OP_SLT = ALU_OPW'(9);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic is_shift(input logic [ALU_OPW-1:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: single-cycle result/carry plus a one-bit shift step.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned OPW   = ALU_OPW
) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic [WIDTH-1:0] step
);

   logic [WIDTH:0] sum;
   logic           lt;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      lt     = $signed(a) < $signed(b);
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         // A zero-length shift completes immediately with the operand unchanged
         OP_SLL, OP_SRL, OP_SRA: result = a;
         OP_SLT: result = {{(WIDTH-1){1'b0}}, lt};
         default: ;
      endcase
   end

   always_comb begin
      step = a;
      case (op)
         OP_SLL: step = {a[WIDTH-2:0], 1'b0};
         OP_SRL: step = {1'b0, a[WIDTH-1:1]};
         OP_SRA: step = {a[WIDTH-1], a[WIDTH-1:1]};
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one op in flight,
// shifts iterate one bit per cycle, response held until consumed.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned OPW   = ALU_OPW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_zero,
   output logic             resp_carry
);

   localparam int unsigned CW = ALU_SHW;

   state_t           state, state_next;
   logic             last_grant;
   logic             grant0, grant1, sel, accept, load_shift;
   logic [OPW-1:0]   op_q;
   logic             id_q;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic [OPW-1:0]   core_op;
   logic [WIDTH-1:0] core_a, core_b, core_result, core_step;
   logic             core_carry;

   alu_core #(.WIDTH(WIDTH), .OPW(OPW)) u_core (
      .op     (core_op),
      .a      (core_a),
      .b      (core_b),
      .result (core_result),
      .carry  (core_carry),
      .step   (core_step)
   );

   // Next state, grants and ALU operand steering
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      load_shift = 1'b0;
      grant0     = req0_valid & (~req1_valid | last_grant);
      grant1     = req1_valid & (~req0_valid | ~last_grant);
      sel        = grant1;
      core_op    = sel ? req1_op : req0_op;
      core_a     = sel ? req1_a  : req0_a;
      core_b     = sel ? req1_b  : req0_b;
      case (state)
         IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            accept     = grant0 | grant1;
            load_shift = is_shift(core_op) && (core_b[CW-1:0] != '0);
            if (accept) state_next = load_shift ? SHIFT : DONE;
         end
         SHIFT: begin
            core_op = op_q;
            core_a  = shreg;
            core_b  = '0;
            if (cnt == CW'(1)) state_next = DONE;
         end
         DONE: begin
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Operand latch, shift iteration and registered response
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant  <= 1'b1;
         op_q        <= '0;
         id_q        <= 1'b0;
         shreg       <= '0;
         cnt         <= '0;
         resp_valid  <= 1'b0;
         resp_id     <= 1'b0;
         resp_result <= '0;
         resp_zero   <= 1'b0;
         resp_carry  <= 1'b0;
      end else begin
         resp_valid <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= sel;
                  id_q       <= sel;
                  op_q       <= core_op;
                  if (load_shift) begin
                     shreg <= core_a;
                     cnt   <= core_b[CW-1:0];
                  end else begin
                     resp_result <= core_result;
                     resp_zero   <= (core_result == '0);
                     resp_carry  <= core_carry;
                     resp_id     <= sel;
                  end
               end
            end
            SHIFT: begin
               shreg <= core_step;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  resp_result <= core_step;
                  resp_zero   <= (core_step == '0);
                  resp_carry  <= 1'b0;
                  resp_id     <= id_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
